round_pipe: RTL and testbench
=============================

// Module: round_pipe
// PURPOSE
//  Parametrised, pipelined fixed-point rounder. Drops FRAC_W fractional bits from an unsigned
//  magnitude using a per-beat rounding mode, saturating instead of wrapping on carry-out.
//  Sits between magnitude/datapath stages and display/output formatting.
//  Valid/ready streaming on both sides.
// PARAMETERS
//  IN_W    17  input magnitude width (bits); IN_W > FRAC_W
//  FRAC_W   4  fractional bits removed; FRAC_W >= 1
//  (localparam OUT_W = IN_W - FRAC_W, result width; default 13)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst_n      in   1      synchronous active-low reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept input beat
//  in_mag     in   IN_W   unsigned magnitude, FRAC_W fractional bits
//  in_mode    in   2      00 truncate, 01 half-up, 10 half-even, 11 ceil
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  OUT_W  rounded integer result
//  out_sat    out  1      result was clamped to all-ones
//  sat_clr    in   1      clears sat_count (feature macro only)
//  sat_count  out  16     saturation event count (feature macro only, else 0)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): s1/s2 valid=0; out_valid=0, out_data=0, out_sat=0, sat_count=0.
//    Any in-flight beats are discarded; in_ready=1 in the cycle after reset releases.
//  - Two register stages; latency 2 cycles from input handshake to out_valid with no stall.
//  - Stage 1 registers int=in_mag[IN_W-1:FRAC_W] and inc, computed from:
//    guard=in_mag[FRAC_W-1]; sticky=|in_mag[FRAC_W-2:0] (0 when FRAC_W=1); lsb=in_mag[FRAC_W].
//    00: inc=0. 01: inc=guard. 10: inc=guard&(sticky|lsb). 11: inc=guard|sticky.
//  - Stage 2: if inc && int=={OUT_W{1'b1}}: out_data=all ones, out_sat=1.
//    Else out_data=int+inc, out_sat=0. No wrap ever.
//  - Handshake: a transfer occurs when valid&&ready in the same cycle.
//    adv2 = !s2_valid | out_ready; adv1 = !s1_valid | adv2; in_ready = adv1 (combinational).
//  - out_data/out_sat are held stable while out_valid && !out_ready.
//  - Full throughput of 1 beat/cycle when out_ready=1. A beat never duplicates or drops under stalls.
//  - in_mode is sampled with its beat and travels with it. Mixed modes back-to-back are legal.
//  - When out_valid=0, out_data/out_sat hold their last value; no X propagation.
// CONFIGURATION
//  ROUND_SAT_CNT_EN defined: sat_count increments on each output handshake with out_sat=1.
//    It saturates at 16'hFFFF and never wraps. sat_clr=1 zeroes it next cycle.
//    If sat_clr=1 and a counted handshake coincide, the clear wins (count=0).
//  Not defined: counter logic absent; sat_count tied to 0; sat_clr ignored.
// TESTING (defaults IN_W=17, FRAC_W=4)
//  1. Mode 01: mag 0x00018 -> 2; 0x00028 -> 3; 0x00027 -> 2; out_sat=0; latency exactly 2 cycles.
//  2. Mode 10: 0x00018 -> 2; 0x00028 -> 2; 0x00029 -> 3. Mode 00: 0x0002F -> 2.
//     Mode 11: 0x00021 -> 3; 0x00020 -> 2.
//  3. Saturation: 0x1FFF8 mode 01 -> 0x1FFF with out_sat=1. Same input in mode 00 -> 0x1FFF, out_sat=0.
//  4. Backpressure: stream 0..99 (mag=k<<4, mode 01) with random out_ready.
//     Outputs must be exactly 0..99 in order; data stable while stalled.
//     in_ready=0 only when both stages are full and out_ready=0.
//  5. Reset mid-stream: with 2 beats in flight, assert rst_n=0 for 1 cycle.
//     out_valid=0 next cycle; no stale beat ever emitted.
//  6. ROUND_SAT_CNT_EN: 3 saturating beats -> sat_count=3.
//     sat_clr coincident with 4th beat -> 0. Without the macro: sat_count stays 0.

Source files
------------

// File: rtl/round_pipe.sv
// round_pipe: two-stage saturating fixed-point rounder; define ROUND_SAT_CNT_EN to add the saturation event counter
module round_pipe #(
  parameter int IN_W = 17,
  parameter int FRAC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_mag,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IN_W-FRAC_W-1:0] out_data,
  output logic                   out_sat,
  input  logic                   sat_clr,
  output logic [15:0]            sat_count
);
  localparam int OUT_W = IN_W - FRAC_W;
  logic             r_s1_valid, r_s1_inc, r_s2_valid, r_sat;
  logic [OUT_W-1:0] r_s1_int, r_data;
  logic             w_adv1, w_adv2, w_guard, w_sticky, w_lsb, w_inc, w_sat;
  logic [OUT_W-1:0] w_sum;
  assign w_adv2    = !r_s2_valid | out_ready;
  assign w_adv1    = !r_s1_valid | w_adv2;
  assign in_ready  = w_adv1;
  assign out_valid = r_s2_valid;
  assign out_data  = r_data;
  assign out_sat   = r_sat;
  assign w_guard   = in_mag[FRAC_W-1];
  assign w_lsb     = in_mag[FRAC_W];
  generate
    if (FRAC_W > 1) begin : g_sticky
      assign w_sticky = |in_mag[FRAC_W-2:0];
    end else begin : g_no_sticky
      assign w_sticky = 1'b0;
    end
  endgenerate
  // Round-increment decision for the incoming beat, selected by its own mode
  always_comb begin
    w_inc = in_mode == 2'b00 ? 1'b0 :
            in_mode == 2'b01 ? w_guard :
            in_mode == 2'b10 ? w_guard & (w_sticky | w_lsb) :
                               w_guard | w_sticky;
  end
  assign w_sat = r_s1_inc & (&r_s1_int);
  assign w_sum = r_s1_int + OUT_W'(r_s1_inc);
  // Stage 1: capture integer part and increment flag on input handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_int   <= '0;
      r_s1_inc   <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_int <= in_mag[IN_W-1:FRAC_W];
        r_s1_inc <= w_inc;
      end
    end
  end
  // Stage 2: apply increment, clamping to all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_data     <= '0;
      r_sat      <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= w_sat ? {OUT_W{1'b1}} : w_sum;
        r_sat  <= w_sat;
      end
    end
  end
`ifdef ROUND_SAT_CNT_EN
  logic [15:0] r_sat_count;
  assign sat_count = r_sat_count;
  // Saturating count of delivered clamped results; clear has priority
  always_ff @(posedge clk) begin
    if (!rst_n || sat_clr)
      r_sat_count <= '0;
    else if (r_s2_valid && out_ready && r_sat && r_sat_count != 16'hFFFF)
      r_sat_count <= r_sat_count + 16'd1;
  end
`else
  assign sat_count = {15'd0, sat_clr & 1'b0};
`endif
endmodule

// File: tb/tb_round_pipe.sv
// tb_round_pipe: directed self-checking bench for round_pipe (defaults IN_W=17, FRAC_W=4)
module tb_round_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_mag = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_data;
  logic        out_sat;
  logic        sat_clr = 1'b0;
  logic [15:0] sat_count;
  int total = 0;
  int bad = 0;

  round_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  localparam int NV = 14;
  logic [16:0] v_mag  [NV] = '{17'h00018, 17'h00028, 17'h00027, 17'h00018, 17'h00028, 17'h00029, 17'h0002F,
                               17'h00021, 17'h00020, 17'h1FFF8, 17'h1FFF8, 17'h1FFF1, 17'h1FFF8, 17'h1FFF7};
  logic [1:0]  v_mode [NV] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00,
                               2'b11, 2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
  logic [12:0] v_exp  [NV] = '{13'd2, 13'd3, 13'd2, 13'd2, 13'd2, 13'd3, 13'd2,
                               13'd3, 13'd2, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF};
  logic        v_sat  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // Drives one beat and waits until it sits at the output (no checking here)
  task automatic push(input logic [16:0] mag, input logic [1:0] mode);
    @(negedge clk);
    in_valid = 1'b1; in_mag = mag; in_mode = mode;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 13'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b want=0", out_sat); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL reset_sat_count got=%0d want=0", sat_count); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_vectors;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mag = v_mag[i]; in_mode = v_mode[i];
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_early_valid got=%b want=0", i, out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_latency got=%b want=1", i, out_valid); end
      total++; if (out_data !== v_exp[i]) begin bad++; $display("FAIL vec%0d_data got=%h want=%h", i, out_data, v_exp[i]); end
      total++; if (out_sat !== v_sat[i]) begin bad++; $display("FAIL vec%0d_sat got=%b want=%b", i, out_sat, v_sat[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int c = 0; c < NV + 3; c++) begin
      @(negedge clk);
      total++; if (out_valid !== (c >= 2 && c - 2 < NV)) begin bad++; $display("FAIL b2b%0d_valid got=%b", c, out_valid); end
      if (c >= 2 && c - 2 < NV) begin
        total++; if (out_data !== v_exp[c-2] || out_sat !== v_sat[c-2]) begin
          bad++; $display("FAIL b2b%0d_data got=%h/%b want=%h/%b", c, out_data, out_sat, v_exp[c-2], v_sat[c-2]);
        end
      end
      in_valid = c < NV;
      if (c < NV) begin in_mag = v_mag[c]; in_mode = v_mode[c]; end
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%b want=1", c, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int sent = 0, got = 0, inflight = 0;
    logic held = 1'b0;
    logic [12:0] hold_d = '0;
    logic hs_in, hs_out;
    for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
      @(negedge clk);
      if (held) begin
        total++; if (out_valid !== 1'b1 || out_data !== hold_d) begin
          bad++; $display("FAIL bp_stall_stable got=%b/%h want=1/%h", out_valid, out_data, hold_d);
        end
      end
      in_valid = sent < 100 && $urandom_range(0, 3) != 0;
      in_mag = 17'(sent << 4); in_mode = 2'b01;
      out_ready = $urandom_range(0, 1) == 1;
      #1;
      total++; if (in_ready !== !(inflight == 2 && !out_ready)) begin
        bad++; $display("FAIL bp_in_ready got=%b inflight=%0d out_ready=%b", in_ready, inflight, out_ready);
      end
      if (out_valid) begin
        total++; if (out_data !== 13'(got) || out_sat !== 1'b0) begin
          bad++; $display("FAIL bp_order got=%0d/%b want=%0d/0", out_data, out_sat, got);
        end
      end
      hs_in = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      held = out_valid && !out_ready;
      hold_d = out_data;
      sent += int'(hs_in); got += int'(hs_out);
      inflight += int'(hs_in) - int'(hs_out);
    end
    total++; if (got != 100) begin bad++; $display("FAIL bp_timeout got=%0d want=100", got); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_mag = 17'h00050; in_mode = 2'b01;
    @(negedge clk);
    in_mag = 17'h00060;
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre_valid got=%b want=1", out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale%0d got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_sat_count;
    logic [15:0] e3, e1;
`ifdef ROUND_SAT_CNT_EN
    e3 = 16'd3; e1 = 16'd1;
`else
    e3 = 16'd0; e1 = 16'd0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(17'h1FFF8, 2'b01);
    @(negedge clk);
    total++; if (sat_count !== e3) begin bad++; $display("FAIL satcnt_three got=%0d want=%0d", sat_count, e3); end
    push(17'h1FFF8, 2'b01);
    total++; if (out_sat !== 1'b1) begin bad++; $display("FAIL satcnt_fourth_sat got=%b want=1", out_sat); end
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL satcnt_clear got=%0d want=0", sat_count); end
    push(17'h1FFF1, 2'b11);
    push(17'h00018, 2'b01);
    @(negedge clk);
    total++; if (sat_count !== e1) begin bad++; $display("FAIL satcnt_after got=%0d want=%0d", sat_count, e1); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_sat_count;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
